// File: rtl/ioctl_sdram_arb.sv
// Packs the data_io download byte stream into 16-bit SDRAM writes through a small FIFO.
// Core reads share the same SDRAM port. Download writes win whenever the arbiter is idle.
module ioctl_sdram_arb #(
  parameter int FIFO_DEPTH = 4,
  parameter bit BLOCK_RD   = 1'b1,
  parameter int AW         = 22
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_ack,
  output logic          rd_valid,
  output logic [15:0]   rd_dout,
  output logic          sdram_req,
  output logic          sdram_we,
  output logic [AW-1:0] sdram_addr,
  output logic [15:0]   sdram_din,
  output logic [1:0]    sdram_dqm,
  input  logic          sdram_ack,
  input  logic          sdram_rdy,
  input  logic [15:0]   sdram_dout,
  output logic          dwnld_done,
  output logic          overflow
);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    logic [1:0]    dqm;
  } wr_ent_t;

  typedef enum logic [1:0] {IDLE, WR, RD, RDWAIT} state_t;

  state_t        state, state_n;
  logic          dl_q, dl_fall, dl_rise;
  logic          hold_vld, hold_vld_n;
  logic [AW-1:0] hold_addr, hold_addr_n;
  logic [7:0]    hold_byte, hold_byte_n;
  logic          pend_vld, pend_vld_n;
  wr_ent_t       pend_ent, pend_ent_n;
  logic          push;
  wr_ent_t       push_ent;
  logic [AW-1:0] wa;
  logic          unused_addr_hi;

  wr_ent_t       mem [FIFO_DEPTH];
  logic [PW:0]   wptr, rptr;
  logic          empty, full, pop, push_ok;
  wr_ent_t       head;
  logic [AW-1:0] rd_addr_q;
  logic          done_pend, done_fire;

  assign wa             = ioctl_addr[AW:1];
  assign unused_addr_hi = ^ioctl_addr[24:AW+1];
  assign dl_fall        = dl_q & ~ioctl_download;
  assign dl_rise        = ~dl_q & ioctl_download;

  // Packer: a mismatched odd byte needs two pushes; the second is parked in pend_ent for one cycle.
  always_comb begin
    push        = 1'b0;
    push_ent    = '0;
    hold_vld_n  = hold_vld;
    hold_addr_n = hold_addr;
    hold_byte_n = hold_byte;
    pend_vld_n  = 1'b0;
    pend_ent_n  = pend_ent;
    if (pend_vld) begin
      push     = 1'b1;
      push_ent = pend_ent;
    end else if (ioctl_wr) begin
      if (!ioctl_addr[0]) begin
        if (hold_vld) begin
          push     = 1'b1;
          push_ent = '{hold_addr, {8'h00, hold_byte}, 2'b10};
        end
        hold_vld_n  = 1'b1;
        hold_addr_n = wa;
        hold_byte_n = ioctl_dout;
      end else if (hold_vld && hold_addr == wa) begin
        push       = 1'b1;
        push_ent   = '{wa, {ioctl_dout, hold_byte}, 2'b00};
        hold_vld_n = 1'b0;
      end else begin
        push       = 1'b1;
        hold_vld_n = 1'b0;
        if (hold_vld) begin
          push_ent   = '{hold_addr, {8'h00, hold_byte}, 2'b10};
          pend_vld_n = 1'b1;
          pend_ent_n = '{wa, {ioctl_dout, 8'h00}, 2'b01};
        end else begin
          push_ent = '{wa, {ioctl_dout, 8'h00}, 2'b01};
        end
      end
    end else if (dl_fall && hold_vld) begin
      push       = 1'b1;
      push_ent   = '{hold_addr, {8'h00, hold_byte}, 2'b10};
      hold_vld_n = 1'b0;
    end
  end

  assign empty   = (wptr == rptr);
  assign full    = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign pop     = (state == WR) && sdram_ack;
  assign push_ok = push && (!full || pop);
  assign head    = mem[rptr[PW-1:0]];

  always_ff @(posedge clk_sys) begin
    if (push_ok) mem[wptr[PW-1:0]] <= push_ent;
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      dl_q      <= 1'b0;
      hold_vld  <= 1'b0;
      hold_addr <= '0;
      hold_byte <= '0;
      pend_vld  <= 1'b0;
      pend_ent  <= '0;
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
    end else begin
      dl_q      <= ioctl_download;
      hold_vld  <= hold_vld_n;
      hold_addr <= hold_addr_n;
      hold_byte <= hold_byte_n;
      pend_vld  <= pend_vld_n;
      pend_ent  <= pend_ent_n;
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // A word being pushed this cycle already beats a read request at IDLE.
  always_comb begin
    state_n    = state;
    sdram_req  = 1'b0;
    sdram_we   = 1'b0;
    sdram_addr = '0;
    sdram_din  = '0;
    sdram_dqm  = '0;
    case (state)
      IDLE: begin
        if (!empty || push)
          state_n = WR;
        else if (rd_req && !(BLOCK_RD && ioctl_download))
          state_n = RD;
      end
      WR: begin
        sdram_req  = 1'b1;
        sdram_we   = 1'b1;
        sdram_addr = head.addr;
        sdram_din  = head.data;
        sdram_dqm  = head.dqm;
        if (sdram_ack) state_n = IDLE;
      end
      RD: begin
        sdram_req  = 1'b1;
        sdram_addr = rd_addr_q;
        if (sdram_ack) state_n = RDWAIT;
      end
      RDWAIT: begin
        if (sdram_rdy) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign done_fire = done_pend && !ioctl_download && !hold_vld && !pend_vld &&
                     empty && !push && (state == IDLE);

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      rd_addr_q  <= '0;
      rd_ack     <= 1'b0;
      rd_valid   <= 1'b0;
      rd_dout    <= '0;
      done_pend  <= 1'b0;
      dwnld_done <= 1'b0;
    end else begin
      if (state == IDLE && state_n == RD) rd_addr_q <= rd_addr;
      rd_ack   <= (state == RD) && sdram_ack;
      rd_valid <= (state == RDWAIT) && sdram_rdy;
      if (state == RDWAIT && sdram_rdy) rd_dout <= sdram_dout;
      if (dl_rise)        done_pend <= 1'b0;
      else if (dl_fall)   done_pend <= 1'b1;
      else if (done_fire) done_pend <= 1'b0;
      dwnld_done <= done_fire;
    end
  end
endmodule

// File: doc/ioctl_sdram_arb.md
Name: ioctl_sdram_arb

Overview:
- Sits between `data_io` and the single SDRAM controller port.
- Packs the `ioctl_wr` byte stream into 16-bit little-endian words, buffers them in a small FIFO and writes them to SDRAM.
- Shares the same SDRAM port with core read requesters; download writes always have priority.
- Flags download completion and FIFO overflow to the core.

Parameters:
- FIFO_DEPTH, 4, number of 16-bit word entries in the write FIFO (power of two, ≥2).
- BLOCK_RD, 1, when 1 core reads are not granted while `ioctl_download`=1.
- AW, 22, SDRAM word-address width.

Ports:
- clk_sys  in  1  system clock; same clock as `data_io` outputs.
- rst  in  1  synchronous reset, active high.
- ioctl_download  in  1  download active.
- ioctl_wr  in  1  byte strobe, one cycle per byte.
- ioctl_addr  in  25  byte address of `ioctl_dout`.
- ioctl_dout  in  8  download byte.
- rd_req  in  1  core read request; held high until `rd_ack`.
- rd_addr  in  AW  core read word address.
- rd_ack  out  1  one-cycle pulse: read accepted by SDRAM.
- rd_valid  out  1  one-cycle pulse: `rd_dout` valid.
- rd_dout  out  16  read data.
- sdram_req  out  1  SDRAM request; held with addr/data until `sdram_ack`.
- sdram_we  out  1  1 = write, 0 = read.
- sdram_addr  out  AW  SDRAM word address.
- sdram_din  out  16  write data.
- sdram_dqm  out  2  byte mask, 1 = lane not written; [0] is low byte, [1] is high byte.
- sdram_ack  in  1  one-cycle pulse: request taken.
- sdram_rdy  in  1  one-cycle pulse: read data valid on `sdram_dout`.
- sdram_dout  in  16  SDRAM read data.
- dwnld_done  out  1  one-cycle pulse: download fully committed to SDRAM.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Reset values:
  - All outputs 0.
  - FIFO empty, packer holding register empty, FSM in IDLE.
  - `overflow` is cleared only by `rst`.
- Word mapping:
  - Word address = `ioctl_addr[AW:1]`.
  - Even byte goes to [7:0]; odd byte goes to [15:8].
- Packer, evaluated on `ioctl_wr`:
  - Even byte, nothing held → hold it with its word address.
  - Odd byte whose word address equals the held address → push {odd, held} with dqm=00; clear hold.
  - Odd byte, nothing held, or address mismatch → first push the held byte (if any) with dqm=10, then push {byte, 8'h00} with dqm=01.
  - Even byte while holding → push the held byte with dqm=10, then hold the new byte.
  - Two pushes in one event are serialized. The second push occurs the next cycle, and `data_io` spacing (≥2 cycles between `ioctl_wr`) guarantees room.
- Flush: on the falling edge of `ioctl_download` with a byte held → push it with dqm=10.
- FIFO:
  - A push while full drops the word and sets `overflow`.
  - A push and a pop in the same cycle on a full FIFO is accepted.
- FSM states:
  - IDLE:
    - FIFO non-empty → WR. Drive the head word, `sdram_we`=1, `sdram_req`=1.
    - Else, `rd_req` and !(BLOCK_RD && `ioctl_download`) → RD. Latch `rd_addr`, `sdram_we`=0, `sdram_req`=1.
  - WR: on `sdram_ack`, pop the FIFO, drop `sdram_req` the same edge, return to IDLE. A back-to-back write starts the following cycle.
  - RD: on `sdram_ack`, pulse `rd_ack`, drop `sdram_req`, → RDWAIT.
  - RDWAIT:
    - On `sdram_rdy`, `rd_dout` ← `sdram_dout`, pulse `rd_valid`, → IDLE.
    - FIFO pushes continue meanwhile; writes wait for IDLE.
- Priority:
  - Writes beat reads only at IDLE. An issued read is never aborted.
  - `rd_req` arriving in the same cycle as the first FIFO word loses.
- dwnld_done:
  - Pulses once, the first cycle in which all of these hold: `ioctl_download`=0 since a falling edge, hold empty, FIFO empty, FSM in IDLE.
  - A rising edge of `ioctl_download` before that cycle cancels the pending pulse.
- `rst` mid-operation:
  - Aborts immediately: `sdram_req` drops and FIFO contents are discarded.
  - The SDRAM controller must tolerate a dropped request.

Test Plan:
- Bytes 0x11@0, 0x22@1, 0x33@2, 0x44@3 at 1 per 4 cycles with `sdram_ack` after 2 cycles → writes (addr0, 0x2211, dqm00) then (addr1, 0x4433, dqm00); one `dwnld_done` after the download falls.
- Single byte 0xA5@6 then download ends → write (addr3, 0x00A5, dqm=10); `dwnld_done` after its ack.
- Byte 0x5A@9 only → write (addr4, 0x5A00, dqm=01); bytes 0x01@10, 0x02@12 → (addr5, dqm10), then (addr6, dqm10) at flush.
- `sdram_ack` held 0 for 40 cycles while 12 bytes stream → 4 words queued, `overflow`=1 after the 5th completed word, later words dropped.
- `rd_req`@0x12345 idle, `sdram_rdy` 6 cycles after ack with 0xBEEF → `rd_ack` pulse, `rd_valid` with `rd_dout`=0xBEEF; with BLOCK_RD=1 and download active → no `rd_ack` until the download falls.
- `rst` asserted during WR with 3 words queued → next cycle `sdram_req`=0, FIFO empty, no `dwnld_done`.
